swcap_phase_ctrl: RTL and testbench
===================================

// Module: swcap_phase_ctrl
// PURPOSE
//  Digital phase controller for a multi-channel interleaved switched-capacitor converter.
//  Generates non-overlapping ph1/ph2 switch controls with programmable phase length and dead time.
//  Rotates channels round-robin, one active channel per period, and optionally pulse-skips on an output comparator.
//  Replaces fixed pulse_gen phase sources in SC converter benches; phase bits drive switch ctrl pins via bit-to-xbit conversion in the enclosing netlist.
// PARAMETERS
//  NCH     default 2  number of interleaved converter channels (>=1)
//  PH_LEN  default 9  clk cycles each phase (ph1 or ph2) is asserted (>=1)
//  DEAD    default 1  clk cycles all phases low between ph1 and ph2, and between ph2 and next ph1 (>=1)
//  CW      default 16 width of skip counter
// PORTS
//  clk          input   1            controller clock, all logic on rising edge
//  rst          input   1            synchronous reset, active-high
//  en           input   1            run request; sampled at period boundaries only
//  vout_low     input   1            comparator: 1 = output below target, charge transfer needed
//  ph1          output  NCH          charge-phase controls, one bit per channel
//  ph2          output  NCH          transfer-phase controls, one bit per channel
//  chan_idx     output  clog2(NCH)   channel that runs the current or next period
//  period_done  output  1            1-cycle pulse on last DEAD cycle of a completed period
//  skip_cnt     output  CW           saturating count of skipped periods
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, chan_idx 0; rst overrides everything, incl. mid-phase (outputs 0 after that edge).
//  - States: IDLE, PH1, DEAD1, PH2, DEAD2, SKIP. All outputs registered.
//  - Decision point D (in IDLE each cycle, and on last DEAD2 cycle):
//      !en -> IDLE; en & skip-condition -> SKIP; else -> PH1. Back-to-back periods are gapless.
//  - PH1: ph1[chan_idx]=1 for PH_LEN cycles -> DEAD1: all 0 for DEAD cycles -> PH2: ph2[chan_idx]=1 for PH_LEN -> DEAD2: all 0 for DEAD.
//  - Period length T = 2*(PH_LEN+DEAD). Latency: en sampled 1 in IDLE at edge k -> ph1 high from edge k.
//  - period_done high on last DEAD2 cycle; chan_idx increments mod NCH on the same edge that leaves DEAD2.
//  - en falling mid-period: period completes in full (no truncated phase), then IDLE.
//  - SKIP: all phases 0 for exactly T cycles; skip_cnt+1 on entry, saturates at 2^CW-1; chan_idx unchanged; exit via decision D.
//  - Invariants: ph1 & ph2 never both nonzero; at most one bit of ph1|ph2 set; no ph1->ph2 or ph2->ph1 transition without >=DEAD zero cycles.
//  - Illegal parameters (NCH<1, PH_LEN<1, DEAD<1) fail elaboration via $error.
// CONFIGURATION
//  SWCAP_SKIP_EN defined: skip-condition = !vout_low; SKIP state and skip_cnt active.
//  SWCAP_SKIP_EN undefined: skip-condition = 0; vout_low ignored; SKIP unreachable; skip_cnt tied to 0; converter free-runs while en=1.
// TESTING (NCH=2, PH_LEN=9, DEAD=1, T=20)
//  1. rst then en=1, vout_low=1 -> ph1[0] cycles 0-8, zero cycle 9, ph2[0] 10-18, period_done at 19; next period ph1[1] from cycle 20.
//  2. 2000 cycles random en/vout_low -> invariants never violated; every completed period exactly 20 cycles; chan_idx alternates 0,1.
//  3. SWCAP_SKIP_EN, en=1, vout_low=0 for 60 cycles then 1 -> no phases for 60 cycles, skip_cnt=3, resumes with ph1[chan_idx unchanged].
//  4. en dropped at cycle 12 (in PH2) -> ph2[0] still ends at cycle 18, period_done at 19, then IDLE with all outputs 0.
//  5. rst pulsed during PH1 of channel 1 with skip_cnt=5 -> next edge: ph1=ph2=0, chan_idx=0, skip_cnt=0, state IDLE.
//  6. SWCAP_SKIP_EN undefined, en=1, vout_low=0 held 100 cycles -> 5 full periods, skip_cnt stays 0.

Source files
------------

// File: rtl/swcap_phase_if.sv
// Handshake-free control bundle between the phase controller and its converter bench.
// The master drives run/comparator requests; the slave returns phase controls and status.
interface swcap_phase_if #(
  parameter int NCH = 2,
  parameter int CW  = 16,
  parameter int CIW = 1
);
  logic           en;
  logic           vout_low;
  logic [NCH-1:0] ph1;
  logic [NCH-1:0] ph2;
  logic [CIW-1:0] chan_idx;
  logic           period_done;
  logic [CW-1:0]  skip_cnt;
  logic [2:0]     dbg_state;

  modport master (
    output en, vout_low,
    input  ph1, ph2, chan_idx, period_done, skip_cnt, dbg_state
  );

  modport slave (
    input  en, vout_low,
    output ph1, ph2, chan_idx, period_done, skip_cnt, dbg_state
  );
endinterface

// File: rtl/swcap_phase_ctrl.sv
// Non-overlapping ph1/ph2 generator with round-robin channel rotation for an interleaved SC converter.
// Optional comparator pulse-skipping is enabled by defining SWCAP_SKIP_EN.
module swcap_phase_ctrl #(
  parameter int NCH    = 2,
  parameter int PH_LEN = 9,
  parameter int DEAD   = 1,
  parameter int CW     = 16,
  parameter int CIW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  swcap_phase_if.slave bus
);

  localparam int T  = 2 * (PH_LEN + DEAD);
  localparam int TW = $clog2(T);

  if (NCH < 1 || PH_LEN < 1 || DEAD < 1) begin : g_bad_param
    $error("swcap_phase_ctrl: NCH, PH_LEN and DEAD must all be >= 1");
  end

  typedef enum logic [2:0] {IDLE, PH1, DEAD1, PH2, DEAD2, SKIP} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [CIW-1:0] chan_q, chan_d;
  logic [CW-1:0]  skip_q, skip_d;
  logic [NCH-1:0] ph1_q, ph2_q;
  logic           pd_q;
  logic           skip_cond;
  logic           decide;

`ifdef SWCAP_SKIP_EN
  assign skip_cond = !bus.vout_low;
`else
  logic unused_vout_low;
  assign unused_vout_low = bus.vout_low;
  assign skip_cond       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    skip_d  = skip_q;
    decide  = 1'b0;
    case (state_q)
      IDLE: decide = 1'b1;
      PH1: begin
        if (cnt_q == '0) begin
          state_d = DEAD1;
          cnt_d   = TW'(DEAD - 1);
        end else cnt_d = cnt_q - TW'(1);
      end
      DEAD1: begin
        if (cnt_q == '0) begin
          state_d = PH2;
          cnt_d   = TW'(PH_LEN - 1);
        end else cnt_d = cnt_q - TW'(1);
      end
      PH2: begin
        if (cnt_q == '0) begin
          state_d = DEAD2;
          cnt_d   = TW'(DEAD - 1);
        end else cnt_d = cnt_q - TW'(1);
      end
      DEAD2: begin
        if (cnt_q == '0) begin
          decide = 1'b1;
          chan_d = (chan_q == CIW'(NCH - 1)) ? '0 : chan_q + CIW'(1);
        end else cnt_d = cnt_q - TW'(1);
      end
      SKIP: begin
        if (cnt_q == '0) decide = 1'b1;
        else cnt_d = cnt_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Period boundary: en is only honoured here, so a running period always completes.
    if (decide) begin
      if (!bus.en) begin
        state_d = IDLE;
      end else if (skip_cond) begin
        state_d = SKIP;
        cnt_d   = TW'(T - 1);
`ifdef SWCAP_SKIP_EN
        if (skip_q != '1) skip_d = skip_q + CW'(1);
`endif
      end else begin
        state_d = PH1;
        cnt_d   = TW'(PH_LEN - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      skip_q  <= '0;
      ph1_q   <= '0;
      ph2_q   <= '0;
      pd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      skip_q  <= skip_d;
      ph1_q   <= (state_d == PH1) ? (NCH'(1) << chan_d) : '0;
      ph2_q   <= (state_d == PH2) ? (NCH'(1) << chan_d) : '0;
      pd_q    <= (state_d == DEAD2) && (cnt_d == '0);
    end
  end

  assign bus.ph1         = ph1_q;
  assign bus.ph2         = ph2_q;
  assign bus.chan_idx    = chan_q;
  assign bus.period_done = pd_q;
  assign bus.skip_cnt    = skip_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_swcap_phase_ctrl.sv
// Directed and random checks of swcap_phase_ctrl (NCH=2, PH_LEN=9, DEAD=1, T=20).
// Build with SWCAP_SKIP_EN defined to exercise pulse skipping.
module tb_swcap_phase_ctrl;
  localparam int NCH    = 2;
  localparam int PH_LEN = 9;
  localparam int DEAD   = 1;
  localparam int CW     = 16;
  localparam int T      = 2 * (PH_LEN + DEAD);
`ifdef SWCAP_SKIP_EN
  localparam int EXP_SKIP5 = 5;
`else
  localparam int EXP_SKIP5 = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   ncyc = 0;

  swcap_phase_if #(.NCH(NCH), .CW(CW), .CIW(1)) bus ();

  swcap_phase_ctrl #(.NCH(NCH), .PH_LEN(PH_LEN), .DEAD(DEAD), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ph1;
    logic [1:0] ph2;
    logic       chan;
    logic       pd;
  } vec_t;

  vec_t t1[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.vout_low = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_outs(input string name, input logic [1:0] p1, input logic [1:0] p2,
                          input logic ch, input logic pd);
    chk({name, ".ph1"}, 32'(bus.ph1), 32'(p1));
    chk({name, ".ph2"}, 32'(bus.ph2), 32'(p2));
    chk({name, ".chan"}, 32'(bus.chan_idx), 32'(ch));
    chk({name, ".pd"}, 32'(bus.period_done), 32'(pd));
  endtask

  // Continuous invariant monitor: overlap, one-hot, dead time, phase length, period length, rotation.
  logic [1:0] prev_p1, prev_p2;
  int prev_kind, last_kind, zero_run, run_len, ph1_start, exp_chan;
  bit started;

  always @(negedge clk) begin
    int kind;
    if (rst) begin
      prev_p1 = '0; prev_p2 = '0; prev_kind = 0; last_kind = 0;
      zero_run = 0; run_len = 0; started = 1'b0; exp_chan = 0;
    end else if (mon_en) begin
      ncyc++;
      kind = (bus.ph1 != 0) ? 1 : (bus.ph2 != 0) ? 2 : 0;
      chk("inv_overlap", 32'((bus.ph1 != 0) && (bus.ph2 != 0)), 32'd0);
      chk("inv_onehot", 32'($countones(bus.ph1 | bus.ph2) <= 1), 32'd1);
      if (kind != 0 && prev_kind == 0 && last_kind != 0)
        chk("inv_dead_time", 32'(zero_run >= DEAD), 32'd1);
      if (kind != 0 && prev_kind != 0)
        chk("inv_no_direct_switch", 32'({bus.ph1, bus.ph2} == {prev_p1, prev_p2}), 32'd1);
      if (kind == 0 && prev_kind != 0)
        chk("inv_phase_len", 32'(run_len), 32'(PH_LEN));
      if (kind == 1 && prev_kind != 1) begin
        chk("rot_ph1_chan", 32'(bus.ph1), 32'(1 << exp_chan));
        ph1_start = ncyc;
        started   = 1'b1;
      end
      if (bus.period_done) begin
        chk("period_len", 32'(started ? (ncyc - ph1_start) : -1), 32'(T - 1));
        exp_chan = (exp_chan + 1) % NCH;
        started  = 1'b0;
      end
      if (kind == 0) begin
        zero_run++;
        run_len = 0;
      end else begin
        if (kind != prev_kind) run_len = 0;
        run_len++;
        zero_run  = 0;
        last_kind = kind;
      end
      prev_kind = kind;
      prev_p1   = bus.ph1;
      prev_p2   = bus.ph2;
    end
  end

  initial begin
    int idx;
    int pd_count;
    bit found;

    t1[0]  = '{0,  2'b01, 2'b00, 1'b0, 1'b0};
    t1[1]  = '{8,  2'b01, 2'b00, 1'b0, 1'b0};
    t1[2]  = '{9,  2'b00, 2'b00, 1'b0, 1'b0};
    t1[3]  = '{10, 2'b00, 2'b01, 1'b0, 1'b0};
    t1[4]  = '{18, 2'b00, 2'b01, 1'b0, 1'b0};
    t1[5]  = '{19, 2'b00, 2'b00, 1'b0, 1'b1};
    t1[6]  = '{20, 2'b10, 2'b00, 1'b1, 1'b0};
    t1[7]  = '{28, 2'b10, 2'b00, 1'b1, 1'b0};
    t1[8]  = '{29, 2'b00, 2'b00, 1'b1, 1'b0};
    t1[9]  = '{30, 2'b00, 2'b10, 1'b1, 1'b0};
    t1[10] = '{39, 2'b00, 2'b00, 1'b1, 1'b1};
    t1[11] = '{40, 2'b01, 2'b00, 1'b0, 1'b0};

    // Reset state
    do_reset();
    mon_en = 1'b1;
    chk_outs("reset", 2'b00, 2'b00, 1'b0, 1'b0);
    chk("reset.skip_cnt", 32'(bus.skip_cnt), 32'd0);
    chk("reset.state", 32'(bus.dbg_state), 32'd0);

    // Basic two-period sequence, table driven
    bus.en = 1'b1;
    idx = 0;
    for (int k = 0; k <= 40; k++) begin
      step();
      if (idx < 12 && t1[idx].cyc == k) begin
        chk_outs($sformatf("seq1_c%0d", k), t1[idx].ph1, t1[idx].ph2, t1[idx].chan, t1[idx].pd);
        idx++;
      end
    end

    // en dropped in PH2: period completes, then IDLE
    do_reset();
    bus.en = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      if (k == 12) bus.en = 1'b0;
      step();
      if (k == 18) chk_outs("endrop_c18", 2'b00, 2'b01, 1'b0, 1'b0);
      if (k == 19) chk_outs("endrop_c19", 2'b00, 2'b00, 1'b0, 1'b1);
      if (k == 20 || k == 25) begin
        chk_outs($sformatf("endrop_c%0d", k), 2'b00, 2'b00, 1'b1, 1'b0);
        chk($sformatf("endrop_c%0d.state", k), 32'(bus.dbg_state), 32'd0);
      end
    end

`ifdef SWCAP_SKIP_EN
    // Comparator satisfied for 60 cycles: three skipped periods, then resume on same channel
    do_reset();
    bus.en       = 1'b1;
    bus.vout_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (k == 0 || k == 19 || k == 20 || k == 59)
        chk_outs($sformatf("skip_c%0d", k), 2'b00, 2'b00, 1'b0, 1'b0);
    end
    bus.vout_low = 1'b1;
    step();
    chk_outs("skip_resume", 2'b01, 2'b00, 1'b0, 1'b0);
    chk("skip_resume.skip_cnt", 32'(bus.skip_cnt), 32'd3);
`else
    // Skipping compiled out: vout_low ignored, converter free-runs
    do_reset();
    bus.en       = 1'b1;
    bus.vout_low = 1'b0;
    pd_count     = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.period_done) pd_count++;
    end
    chk("noskip.periods", 32'(pd_count), 32'd5);
    chk("noskip.skip_cnt", 32'(bus.skip_cnt), 32'd0);
`endif

    // Reset in the middle of channel 1 PH1
    do_reset();
    bus.en       = 1'b1;
    bus.vout_low = 1'b0;
    found        = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 100) bus.vout_low = 1'b1;
      step();
      if (bus.ph1 == 2'b10) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid.reached_ch1", 32'(found), 32'd1);
    step();
    step();
    chk("rstmid.pre_ph1", 32'(bus.ph1), 32'h2);
    chk("rstmid.pre_skip_cnt", 32'(bus.skip_cnt), 32'(EXP_SKIP5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.en = 1'b0;
    chk_outs("rstmid.post", 2'b00, 2'b00, 1'b0, 1'b0);
    chk("rstmid.skip_cnt", 32'(bus.skip_cnt), 32'd0);
    chk("rstmid.state", 32'(bus.dbg_state), 32'd0);

    // Random en/vout_low; the monitor checks invariants and period lengths
    do_reset();
    pd_count = 0;
    for (int k = 0; k < 2000; k++) begin
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.vout_low = ($urandom_range(0, 3) != 0);
      step();
      if (bus.period_done) pd_count++;
    end
    chk("rand.some_periods", 32'(pd_count > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
